xm23_pic: RTL and testbench

//  Priority interrupt controller feeding the xm23_cpu pic_in/pic_read interface. Watches each device
//  CSR (timer, keyboard, screen, traffic lights, pedestrian button, ...) for data-available events,

---
 rtl/xm23_pkg.sv | 40 ++++
 rtl/xm23_pic_arb.sv | 32 +++
 rtl/xm23_pic.sv | 112 +++++++++++
 tb/tb_xm23_pic.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/xm23_pkg.sv
// xm23_pkg: shared constants for the xm23 device/interrupt slice.
//   CSR bit positions, pic_in field offsets, PIC FSM state enum,
//   device index map and the vector helper.
package xm23_pkg;

  // device CSR bits
  localparam int CSR_IE_BIT  = 0;
  localparam int CSR_OF_BIT  = 1;
  localparam int CSR_DBA_BIT = 2;

  // pic_in word layout: {valid, pri[2:0], vec[3:0]}
  localparam int PIC_VLD_BIT = 7;
  localparam int PIC_PRI_LSB = 4;
  localparam int PIC_VEC_LSB = 0;

  // device index map
  localparam logic [2:0] tmr_csr = 3'd0;
  localparam logic [2:0] kb_csr  = 3'd1;
  localparam logic [2:0] scr_csr = 3'd2;
  localparam logic [2:0] tl_csr  = 3'd3;
  localparam logic [2:0] pb_csr  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_POST = 2'd2,
    S_CLR  = 2'd3
  } pic_state_t;

  // vector = base + index, 4-bit wrap
  function automatic logic [3:0] mk_vec(input logic [3:0] base, input logic [2:0] idx);
    return base + {1'b0, idx};
  endfunction

  function automatic logic [7:0] mk_pic(input logic vld, input logic [2:0] pri,
                                        input logic [3:0] vec);
    return {vld, pri, vec};
  endfunction

endpackage

// File: rtl/xm23_pic_arb.sv
// xm23_pic_arb: combinational priority select.
//   pend    pending flag per device
//   pri     3-bit priority per device
//   cpu_pri current CPU priority; a device must be strictly above it
//   any     some device is eligible
//   idx/pri_o winner index and priority (highest pri, ties -> lowest index)
module xm23_pic_arb #(
  parameter int NUM_DEV = 8
) (
  input  logic [NUM_DEV-1:0]      pend,
  input  logic [NUM_DEV-1:0][2:0] pri,
  input  logic [2:0]              cpu_pri,
  output logic                    any,
  output logic [2:0]              idx,
  output logic [2:0]              pri_o
);

  // Ascending scan with strict '>' keeps the lowest index on ties.
  always_comb begin
    any   = 1'b0;
    idx   = 3'd0;
    pri_o = 3'd0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (pend[i] && (pri[i] > cpu_pri) && (!any || (pri[i] > pri_o))) begin
        any   = 1'b1;
        idx   = 3'(i);
        pri_o = pri[i];
      end
    end
  end

endmodule

// File: rtl/xm23_pic.sv
// xm23_pic: priority interrupt controller for the xm23 CPU pic_in/pic_read port.
//   Clock, Reset  clock, synchronous active-high reset
//   dev_csr       device CSR bytes, device i at [8i+7:8i]
//   cpu_pri       current CPU priority
//   pic_read      CPU acknowledge pulse (honoured only while posting)
//   pri_we/pri_dev/pri_val  priority table write port
//   pic_in        {valid, pri, vector} request word to the CPU (registered)
//   pend          pending flags
//   ovf           sticky overrun flags
module xm23_pic
  import xm23_pkg::*;
#(
  parameter int          NUM_DEV   = 8,
  parameter int          IE_BIT    = CSR_IE_BIT,
  parameter int          DBA_BIT   = CSR_DBA_BIT,
  parameter logic [3:0]  VECT_BASE = 4'd8,
  parameter logic [23:0] PRI_INIT  = 24'h0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [8*NUM_DEV-1:0] dev_csr,
  input  logic [2:0]           cpu_pri,
  input  logic                 pic_read,
  input  logic                 pri_we,
  input  logic [2:0]           pri_dev,
  input  logic [2:0]           pri_val,
  output logic [7:0]           pic_in,
  output logic [NUM_DEV-1:0]   pend,
  output logic [NUM_DEV-1:0]   ovf
);

  pic_state_t state;

  logic [NUM_DEV-1:0]      dba, ie, dba_q, ev, clr;
  logic [NUM_DEV-1:0][2:0] pri;
  logic [2:0]              idx_w, pri_w;
  logic                    a_any;
  logic [2:0]              a_idx, a_pri;

  // only IE and DBA are looked at; the rest of each CSR is the device's business
  logic unused_csr;
  assign unused_csr = ^dev_csr;

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_dev
    assign dba[g] = dev_csr[8*g + DBA_BIT];
    assign ie[g]  = dev_csr[8*g + IE_BIT];
    // an event is a DBA rising edge on an enabled device
    assign ev[g]  = dba[g] & ~dba_q[g] & ie[g];
    // posted winner is released while in CLR
    assign clr[g] = (state == S_CLR) && (idx_w == 3'(g));
  end

  xm23_pic_arb #(.NUM_DEV(NUM_DEV)) u_arb (
    .pend    (pend),
    .pri     (pri),
    .cpu_pri (cpu_pri),
    .any     (a_any),
    .idx     (a_idx),
    .pri_o   (a_pri)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_IDLE;
      pic_in <= 8'h00;
      pend   <= '0;
      ovf    <= '0;
      dba_q  <= '0;
      idx_w  <= 3'd0;
      pri_w  <= 3'd0;
      for (int i = 0; i < NUM_DEV; i++) pri[i] <= PRI_INIT[3*i +: 3];
    end else begin
      dba_q <= dba;
      // a fresh event wins over the clear of the acked device, and is not an overrun
      pend  <= ev | (pend & ~clr);
      ovf   <= ovf | (ev & pend & ~clr);

      for (int i = 0; i < NUM_DEV; i++)
        if (pri_we && (pri_dev == 3'(i))) pri[i] <= pri_val;

      case (state)
        S_IDLE: if (a_any) state <= S_ARB;
        S_ARB: begin
          if (a_any) begin
            // winner is frozen here; later arrivals do not displace it
            idx_w  <= a_idx;
            pri_w  <= a_pri;
            pic_in <= mk_pic(1'b1, a_pri, mk_vec(VECT_BASE, a_idx));
            state  <= S_POST;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_POST: begin
          if (pic_read) begin
            state <= S_CLR;
          end else if (cpu_pri >= pri_w) begin
            // CPU raised its priority: withdraw, device stays pending
            pic_in[PIC_VLD_BIT] <= 1'b0;
            state               <= S_IDLE;
          end
        end
        S_CLR: begin
          pic_in[PIC_VLD_BIT] <= 1'b0;
          state               <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xm23_pic.sv
module tb_xm23_pic;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [63:0] dev_csr;
  logic [2:0]  cpu_pri;
  logic        pic_read;
  logic        pri_we;
  logic [2:0]  pri_dev;
  logic [2:0]  pri_val;
  logic [7:0]  pic_in;
  logic [7:0]  pend;
  logic [7:0]  ovf;

  int n_cmp = 0;
  int n_err = 0;

  xm23_pic dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .dev_csr  (dev_csr),
    .cpu_pri  (cpu_pri),
    .pic_read (pic_read),
    .pri_we   (pri_we),
    .pri_dev  (pri_dev),
    .pri_val  (pri_val),
    .pic_in   (pic_in),
    .pend     (pend),
    .ovf      (ovf)
  );

  always #5 Clock = ~Clock;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic set_pri(input int d, input logic [2:0] v);
    pri_we  = 1'b1;
    pri_dev = 3'(d);
    pri_val = v;
    tick();
    pri_we  = 1'b0;
  endtask

  task automatic set_csr(input int d, input logic [7:0] v);
    dev_csr[8*d +: 8] = v;
  endtask

  task automatic ack();
    pic_read = 1'b1;
    tick();
    pic_read = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    dev_csr  = '0;
    cpu_pri  = 3'd0;
    pic_read = 1'b0;
    pri_we   = 1'b0;
    pri_dev  = 3'd0;
    pri_val  = 3'd0;
    tick(2);
    Reset = 1'b0;
    chk("rst_pic_in", pic_in, 8'h00);
    chk("rst_pend",   pend,   8'h00);
    chk("rst_ovf",    ovf,    8'h00);

    // single device: dev0 pri 3 -> vector 8
    set_pri(0, 3'd3);
    set_csr(0, 8'h05);
    tick();
    chk("t1_pend_set", pend, 8'h01);
    chk("t1_no_post1", {7'd0, pic_in[7]}, 8'h00);
    tick();
    chk("t1_no_post2", {7'd0, pic_in[7]}, 8'h00);
    tick();
    chk("t1_post",     pic_in, 8'hB8);
    tick(2);
    chk("t1_hold",     pic_in, 8'hB8);
    ack();
    chk("t1_clr_still", pic_in, 8'hB8);
    tick();
    chk("t1_drop",     {7'd0, pic_in[7]}, 8'h00);
    chk("t1_pend_clr", pend, 8'h00);
    tick(4);
    chk("t1_no_repost", {7'd0, pic_in[7]}, 8'h00);
    set_csr(0, 8'h00);
    tick();

    // tie: dev1 and dev3 both pri 5 -> dev1 first, then dev3
    set_pri(1, 3'd5);
    set_pri(3, 3'd5);
    set_csr(1, 8'h05);
    set_csr(3, 8'h05);
    tick();
    chk("t2_pend", pend, 8'h0A);
    tick(2);
    chk("t2_post_dev1", pic_in, 8'hD9);
    ack();
    tick();
    chk("t2_drop",  {7'd0, pic_in[7]}, 8'h00);
    chk("t2_pend3", pend, 8'h08);
    tick();
    chk("t2_gap",   {7'd0, pic_in[7]}, 8'h00);
    tick();
    chk("t2_post_dev3", pic_in, 8'hDB);
    ack();
    tick();
    chk("t2_pend_none", pend, 8'h00);
    set_csr(1, 8'h00);
    set_csr(3, 8'h00);
    tick();

    // withdraw on cpu_pri raise, repost on lower
    set_pri(2, 3'd4);
    set_csr(2, 8'h05);
    tick(3);
    chk("t3_post", pic_in, 8'hCA);
    cpu_pri = 3'd4;
    tick();
    chk("t3_withdraw", {7'd0, pic_in[7]}, 8'h00);
    chk("t3_pend_kept", pend, 8'h04);
    tick(3);
    chk("t3_equal_pri_blocked", {7'd0, pic_in[7]}, 8'h00);
    cpu_pri = 3'd2;
    tick(2);
    chk("t3_repost", pic_in, 8'hCA);
    ack();
    tick();
    chk("t3_pend_clr", pend, 8'h00);
    set_csr(2, 8'h00);
    cpu_pri = 3'd0;
    tick();

    // priority 0 is never eligible, even against cpu_pri 0
    set_csr(5, 8'h05);
    tick(4);
    chk("t4_pri0_pend", {7'd0, pend[5]}, 8'h01);
    chk("t4_pri0_no_post", {7'd0, pic_in[7]}, 8'h00);

    // overrun: dev0 rises twice while pending (cpu_pri 7 blocks posting)
    cpu_pri = 3'd7;
    set_csr(0, 8'h05);
    tick();
    chk("t5_pend0", {7'd0, pend[0]}, 8'h01);
    chk("t5_no_ovf", ovf, 8'h00);
    set_csr(0, 8'h01);
    tick();
    set_csr(0, 8'h05);
    tick();
    chk("t5_ovf", ovf, 8'h01);
    // IE=0 rise on dev4 latches nothing
    set_csr(4, 8'h04);
    tick();
    chk("t5_ie0_pend4", {7'd0, pend[4]}, 8'h00);
    chk("t5_ie0_ovf",  ovf, 8'h01);

    // reset while posting
    cpu_pri = 3'd0;
    tick(2);
    chk("t6_post", pic_in, 8'hB8);
    Reset = 1'b1;
    tick();
    chk("t6_rst_pic_in", pic_in, 8'h00);
    chk("t6_rst_pend",   pend,   8'h00);
    chk("t6_rst_ovf",    ovf,    8'h00);
    Reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
